bit_serial_addsub: RTL and testbench

Parametrised bit-serial adder/subtractor with a start/done handshake. It captures two WIDTH-bit operands and processes one bit per clock, LSB first, through a single full-adder slice and a registered carry. After completion it presents the sum/difference, carry-out and signed overflow on held output registers. It is the multi-width, subtract-capable, handshaked successor of the team's fixed 8-bit serial adder, for datapaths where area matters more than latency.

---
 rtl/bit_serial_addsub.sv | 115 +++++++++++
 tb/tb_bit_serial_addsub.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice, LSB first,
// start/done handshake, result held until the next completion.
module bit_serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic s, co;

  assign s  = opa_q[0] ^ opb_q[0] ^ c_q;
  assign co = (opa_q[0] & opb_q[0])
            | (opa_q[0] & c_q)
            | (opb_q[0] & c_q);

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          opa_d   = A;
          opb_d   = sub ? ~B : B;
          c_d     = sub;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        opa_d = opa_q >> 1;
        opb_d = opb_q >> 1;
        acc_d = {s, acc_q[WIDTH-1:1]};
        c_d   = co;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d   = {s, acc_q[WIDTH-1:1]};
          cout_d  = co;
          // carry into the MSB differs from carry out => signed overflow
          ovf_d   = co ^ c_q;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_bit_serial_addsub.sv
// Directed bench for bit_serial_addsub at WIDTH 8, 16 and 2.
module tb_bit_serial_addsub;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       start8 = 0, sub8 = 0;
  logic [7:0] A8 = 0, B8 = 0;
  logic       busy8, done8, Cout8, Ovf8;
  logic [7:0] Sum8;

  logic        start16 = 0, sub16 = 0;
  logic [15:0] A16 = 0, B16 = 0;
  logic        busy16, done16, Cout16, Ovf16;
  logic [15:0] Sum16;

  logic       start2 = 0, sub2 = 0;
  logic [1:0] A2 = 0, B2 = 0;
  logic       busy2, done2, Cout2, Ovf2;
  logic [1:0] Sum2;

  bit_serial_addsub #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .sub(sub8),
    .A(A8), .B(B8), .busy(busy8), .done(done8),
    .Sum(Sum8), .Cout(Cout8), .Ovf(Ovf8)
  );

  bit_serial_addsub #(.WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .start(start16), .sub(sub16),
    .A(A16), .B(B16), .busy(busy16), .done(done16),
    .Sum(Sum16), .Cout(Cout16), .Ovf(Ovf16)
  );

  bit_serial_addsub #(.WIDTH(2)) u2 (
    .clk(clk), .reset(reset), .start(start2), .sub(sub2),
    .A(A2), .B(B2), .busy(busy2), .done(done2),
    .Sum(Sum2), .Cout(Cout2), .Ovf(Ovf2)
  );

  task automatic test_reset();
    #3;
    checks++;
    if ({busy8, done8, Sum8, Cout8, Ovf8} !== 12'h0) begin
      errors++;
      $display("FAIL reset_w8: got busy=%b done=%b Sum=%h Cout=%b Ovf=%b, expected all 0",
               busy8, done8, Sum8, Cout8, Ovf8);
    end
    checks++;
    if ({busy16, done16, Sum16, Cout16, Ovf16} !== 20'h0) begin
      errors++;
      $display("FAIL reset_w16: got Sum=%h busy=%b done=%b, expected all 0",
               Sum16, busy16, done16);
    end
    checks++;
    if ({busy2, done2, Sum2, Cout2, Ovf2} !== 6'h0) begin
      errors++;
      $display("FAIL reset_w2: got Sum=%h busy=%b done=%b, expected all 0",
               Sum2, busy2, done2);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // Full handshake check on the 8-bit instance.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic s, input logic [7:0] es,
                     input logic ec, input logic eo, input string nm);
    logic [7:0] prev;
    int busy_cnt;
    int bad_mid;
    prev = Sum8;
    @(negedge clk);
    A8 = a; B8 = b; sub8 = s; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    busy_cnt = 0;
    bad_mid = 0;
    for (int k = 0; k < 8; k++) begin
      if (busy8) busy_cnt++;
      if (done8 || Sum8 !== prev) bad_mid++;
      @(posedge clk); #1;
    end
    checks++;
    if (busy_cnt != 8 || bad_mid != 0) begin
      errors++;
      $display("FAIL %s_run: busy cycles=%0d early done/Sum change=%0d, expected 8 and 0",
               nm, busy_cnt, bad_mid);
    end
    checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: got done=%b busy=%b, expected 1 0", nm, done8, busy8);
    end
    checks++;
    if (Sum8 !== es || Cout8 !== ec || Ovf8 !== eo) begin
      errors++;
      $display("FAIL %s_result: got Sum=%h Cout=%b Ovf=%b, expected Sum=%h Cout=%b Ovf=%b",
               nm, Sum8, Cout8, Ovf8, es, ec, eo);
    end
    @(posedge clk); #1;
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0 || Sum8 !== es) begin
      errors++;
      $display("FAIL %s_idle: got done=%b busy=%b Sum=%h, expected 0 0 %h",
               nm, done8, busy8, Sum8, es);
    end
  endtask

  task automatic test_add();
    op8(8'd100, 8'd27, 1'b0, 8'd127, 1'b0, 1'b0, "add_100_27");
    op8(8'd200, 8'd100, 1'b0, 8'd44, 1'b1, 1'b0, "add_200_100");
    op8(8'd100, 8'd50, 1'b0, 8'h96, 1'b0, 1'b1, "add_100_50");
  endtask

  task automatic test_sub();
    op8(8'd5, 8'd7, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_5_7");
    op8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");
  endtask

  task automatic test_ignore_inputs();
    logic [7:0] prev;
    int bad;
    prev = Sum8;
    @(negedge clk);
    A8 = 8'd100; B8 = 8'd27; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (Sum8 !== prev || !busy8) bad++;
      @(negedge clk);
      start8 = ~start8;
      A8 = ~A8 + 8'd3;
      B8 = B8 ^ 8'h5A;
      sub8 = ~sub8;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL toggle_run: %0d bad samples during RUN, expected 0", bad);
    end
    checks++;
    if (Sum8 !== 8'd127 || Cout8 !== 1'b0 || Ovf8 !== 1'b0 || done8 !== 1'b1) begin
      errors++;
      $display("FAIL toggle_result: got Sum=%h Cout=%b Ovf=%b done=%b, expected 7f 0 0 1",
               Sum8, Cout8, Ovf8, done8);
    end
    @(negedge clk);
    start8 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      errors++;
      $display("FAIL toggle_done_start: got busy=%b done=%b, expected 0 0", busy8, done8);
    end
    @(negedge clk);
    start8 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy8 !== 1'b0 || Sum8 !== 8'd127) begin
      errors++;
      $display("FAIL toggle_no_queue: got busy=%b Sum=%h, expected 0 7f", busy8, Sum8);
    end
  endtask

  task automatic test_abort();
    int seen_done;
    @(negedge clk);
    A8 = 8'd100; B8 = 8'd27; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, Sum8, Cout8, Ovf8} !== 12'h0) begin
      errors++;
      $display("FAIL abort_async: got busy=%b done=%b Sum=%h Cout=%b Ovf=%b, expected all 0",
               busy8, done8, Sum8, Cout8, Ovf8);
    end
    seen_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done8) seen_done++;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (done8 || busy8) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL abort_no_done: %0d done/busy samples, expected 0", seen_done);
    end
    op8(8'd1, 8'd1, 1'b0, 8'd2, 1'b0, 1'b0, "after_abort");
  endtask

  task automatic test_wide();
    int lat;
    @(negedge clk);
    A16 = 16'hFFFF; B16 = 16'h0001; sub16 = 1'b0; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 0;
    while (!done16 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 16) begin
      errors++;
      $display("FAIL w16_latency: got %0d edges, expected 16", lat);
    end
    checks++;
    if (Sum16 !== 16'h0000 || Cout16 !== 1'b1 || Ovf16 !== 1'b0) begin
      errors++;
      $display("FAIL w16_result: got Sum=%h Cout=%b Ovf=%b, expected 0000 1 0",
               Sum16, Cout16, Ovf16);
    end
  endtask

  task automatic test_narrow();
    int lat;
    @(negedge clk);
    A2 = 2'd1; B2 = 2'd1; sub2 = 1'b0; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    lat = 0;
    while (!done2 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL w2_latency: got %0d edges, expected 2", lat);
    end
    checks++;
    if (Sum2 !== 2'b10 || Cout2 !== 1'b0 || Ovf2 !== 1'b1) begin
      errors++;
      $display("FAIL w2_result: got Sum=%b Cout=%b Ovf=%b, expected 10 0 1",
               Sum2, Cout2, Ovf2);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ignore_inputs();
    test_abort();
    test_wide();
    test_narrow();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
